ol_tx_arbiter: RTL

- Shares the 16-bit optical-link TX word stream between N_REQ on-board data sources (trigger primitives, status, monitoring).
- Frames each source's packet as header, payload and checksum trailer.
- Inserts K-character idle words between packets.
- Feeds the data-mode TX input of the optical-link controller. Transmits only while that controller reports the link is live.

---
 rtl/ol_pkg.sv | 22 ++
 rtl/ol_rr_arbiter.sv | 34 +++
 rtl/ol_tx_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ol_pkg.sv
// Shared optical-link TX definitions: framing FSM states, idle/comma word, header layout.
package ol_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_TRL  = 2'd3
    } ol_state_e;

    localparam logic [15:0] OL_IDLE_WORD = 16'h50BC;
    localparam logic [1:0]  OL_IDLE_K    = 2'b01;
    localparam logic [3:0]  OL_HDR_TAG   = 4'hA;

    // Header word: tag [15:12], source id [11:8], payload length [7:0]
    typedef struct packed {
        logic [3:0] tag;
        logic [3:0] src;
        logic [7:0] len;
    } ol_hdr_t;

endpackage

// File: rtl/ol_rr_arbiter.sv
// Round-robin pick: first requester after 'last' (wrapping) wins; purely combinational.
// Zero latency; no backpressure, the caller decides when to accept the pick.
module ol_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   last,
    output logic [N-1:0] gnt,
    output logic [3:0]   idx,
    output logic         any
);

    // Scan indices above 'last' first, then wrap around from 0 up to 'last'.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i > int'(last))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = 4'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i <= int'(last))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/ol_tx_arbiter.sv
// Frames requester packets (header, payload, checksum trailer) onto the link TX word stream, idles between.
// Header one cycle after arbitration, trailer at len+2; link_up low aborts the packet and blocks new ones.
module ol_tx_arbiter
    import ol_pkg::*;
#(
    parameter int          N_REQ     = 4,
    parameter logic [15:0] IDLE_WORD = OL_IDLE_WORD,
    parameter logic [1:0]  IDLE_K    = OL_IDLE_K,
    parameter logic [3:0]  HDR_TAG   = OL_HDR_TAG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  link_up,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [8*N_REQ-1:0]    req_len,
    input  logic [16*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_rd,
    output logic [N_REQ-1:0]      grant,
    output logic [15:0]           tx_data,
    output logic [1:0]            tx_datak,
    output logic                  pkt_done,
    output logic                  pkt_abort,
    output logic [15:0]           pkt_count
);

    ol_state_e          state_q, state_d;
    logic [3:0]         g_q, g_d;
    logic [3:0]         last_q, last_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   rd_q, rd_d;
    logic [7:0]         rem_q, rem_d;
    logic [15:0]        acc_q, acc_d;
    logic [15:0]        tx_data_q, tx_data_d;
    logic [1:0]         tx_datak_q, tx_datak_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic [15:0]        count_q, count_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [3:0]         arb_idx;
    logic               arb_any;
    logic [7:0]         arb_len;
    logic [15:0]        head_dat;
    ol_hdr_t            hdr;

    ol_rr_arbiter #(.N(N_REQ)) u_rr (
        .req  (req_valid),
        .last (last_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    always_comb begin
        head_dat = '0;
        arb_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i])   head_dat = req_data[16*i +: 16];
            if (arb_gnt[i]) arb_len  = req_len[8*i +: 8];
        end
    end

    // Outputs are registered, so each state computes the word shown during the next state.
    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        rd_d       = '0;
        rem_d      = rem_q;
        acc_d      = acc_q;
        tx_data_d  = IDLE_WORD;
        tx_datak_d = IDLE_K;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        count_d    = count_q;
        hdr        = '{tag: HDR_TAG, src: arb_idx, len: arb_len};

        if (state_q == ST_IDLE) begin
            if (link_up && arb_any) begin
                state_d    = ST_HDR;
                g_d        = arb_idx;
                gnt_d      = arb_gnt;
                rem_d      = arb_len;
                tx_data_d  = hdr;
                tx_datak_d = 2'b00;
                acc_d      = hdr;
                rd_d       = (arb_len != 8'd0) ? arb_gnt : '0;
            end
        end else if (!link_up) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            abort_d = 1'b1;
            last_d  = g_q;
        end else begin
            case (state_q)
                ST_HDR, ST_PAY: begin
                    tx_datak_d = 2'b00;
                    // In HDR rem_q==0 means an empty payload; in PAY rem_q counts words still to show.
                    if ((state_q == ST_HDR) ? (rem_q != 8'd0) : (rem_q > 8'd1)) begin
                        state_d   = ST_PAY;
                        tx_data_d = head_dat;
                        acc_d     = acc_q + head_dat;
                        if (state_q == ST_HDR) begin
                            rd_d = (rem_q > 8'd1) ? gnt_q : '0;
                        end else begin
                            rem_d = rem_q - 8'd1;
                            rd_d  = (rem_q > 8'd2) ? gnt_q : '0;
                        end
                    end else begin
                        state_d   = ST_TRL;
                        tx_data_d = acc_q;
                        done_d    = 1'b1;
                        count_d   = count_q + 16'd1;
                    end
                end
                ST_TRL: begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    last_d  = g_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            g_q        <= '0;
            last_q     <= 4'(N_REQ - 1);
            gnt_q      <= '0;
            rd_q       <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            tx_data_q  <= IDLE_WORD;
            tx_datak_q <= IDLE_K;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            rd_q       <= rd_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            tx_data_q  <= tx_data_d;
            tx_datak_q <= tx_datak_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            count_q    <= count_d;
        end
    end

    // A pop must stop in the very cycle the link drops, before the registered state catches up.
    assign req_rd    = rd_q & {N_REQ{link_up}};
    assign grant     = gnt_q;
    assign tx_data   = tx_data_q;
    assign tx_datak  = tx_datak_q;
    assign pkt_done  = done_q;
    assign pkt_abort = abort_q;
    assign pkt_count = count_q;

endmodule
